ram_write_arbiter: RTL
======================

Name: ram_write_arbiter

Overview:
- Shares the single framebuffer line-RAM write port between two byte-stream requesters.
  - req0: UART line loader.
  - req1: secondary writer, e.g. a fill/clear engine.
- Grants by round-robin and locks the grant for a whole burst, terminated by a beat flagged last.
- Owns RAM strobe timing: ram_write_enable plus a multi-cycle ram_clk_enable window per byte.
- Sits between the command decoders and the RAM port.

Parameters:
- ADDR_WIDTH, 12, RAM address width.
- DATA_WIDTH, 8, RAM data width.
- CE_CYCLES, 2, cycles ram_clk_enable is held per write. Legal range 1..15.
- TIMEOUT_CYCLES, 255, idle cycles tolerated mid-burst before forced release. Legal range 1..255. Used only with the watchdog.

Ports:
- clk_in  in  1  system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high.
- req0_valid  in  1  requester 0 beat valid.
- req0_addr  in  ADDR_WIDTH  requester 0 beat address.
- req0_data  in  DATA_WIDTH  requester 0 beat data.
- req0_last  in  1  final beat of requester 0 burst.
- req0_ready  out  1  requester 0 beat accepted when ready & valid.
- req1_valid, req1_addr, req1_data, req1_last, req1_ready: same as req0, for requester 1.
- ram_data_out  out  DATA_WIDTH  registered write data.
- ram_address  out  ADDR_WIDTH  registered write address.
- ram_write_enable  out  1  write strobe.
- ram_clk_enable  out  1  RAM clock-enable window.
- grant  out  2  one-hot current owner; 00 when idle.
- busy  out  1  state != IDLE.
- timeout_err  out  1  one-cycle pulse on watchdog release.

Behaviour:
- Reset (async, any state):
  - All outputs 0 immediately; state IDLE.
  - Round-robin pointer last_grant = 1, so req0 wins the first contention.
- States: IDLE, GRANT, WRITE.
- IDLE:
  - ready outputs 0; no beat is accepted.
  - If exactly one valid is high, grant it.
  - If both are high, grant the requester != last_grant.
  - The registered grant takes effect next cycle, so first-beat ready follows valid by 1 cycle.
- GRANT:
  - req_ready[g] = (state==GRANT) & grant[g]; combinational from registered state only, never from valid.
  - Non-granted ready stays 0; that requester's valid stays pending and is never dropped.
  - On valid & ready: capture addr/data into ram_address/ram_data_out, set ram_write_enable = 1, load CE counter = CE_CYCLES, store beat_last, go to WRITE.
- WRITE:
  - ram_clk_enable = 1 for exactly CE_CYCLES cycles.
  - ram_write_enable stays 1 for the same window.
  - On counter expiry both drop.
    - If beat_last: go to IDLE, last_grant = g, grant = 00.
    - Otherwise: go to GRANT.
- Throughput: one byte per CE_CYCLES+1 cycles.
- ram_address and ram_data_out hold their last value between writes; they are not cleared.
- Burst lock: the other requester is never granted until the owner's last beat completes WRITE (or the watchdog fires).
- Single-beat burst (last=1 on the first beat) is legal.
- A beat presented while in WRITE waits; it is accepted in the next GRANT cycle.
- Exiting WRITE into IDLE with the other requester valid: the grant switches to it on the following cycle.

Optional Feature:
- Macro: RAM_ARB_WATCHDOG_EN.
- Defined:
  - In GRANT, an 8-bit counter increments each cycle the owner's valid is 0 and clears on any accepted beat.
  - When the counter reaches TIMEOUT_CYCLES: go to IDLE, grant = 00, last_grant = g, timeout_err pulses 1 cycle. No RAM write occurs.
- Undefined:
  - No counter is built; the grant is held indefinitely until last.
  - timeout_err is tied 0.

Decomposition:
- Package ram_arb_pkg:
  - State encoding constants (IDLE=0, GRANT=1, WRITE=2).
  - Grant one-hot constants GNT_NONE / GNT_REQ0 / GNT_REQ1.
  - Default widths.
- Sub-module ram_strobe_timer (clk_in, reset, load, count value, running output) produces the CE window.
- Arbitration and state logic stay in the top module.

Test Plan:
- req0 single beat, addr 0x7E3, data 0xA5, last=1, from IDLE:
  - req0_ready high on cycle 1 after valid.
  - ram_address=0x7E3, ram_data_out=0xA5, ram_write_enable=ram_clk_enable=1 for exactly 2 cycles.
  - Then IDLE, grant=00.
- req0 and req1 both valid out of reset, 4-beat bursts each:
  - req0 granted first; all 4 req0 writes complete before req1 ready rises.
  - Next contention grants req0 again (last_grant=1).
- 128-beat req0 burst (addr descending 127..0), req1 valid throughout:
  - Grant stays 01 for 128 writes; no req1 write interleaved.
  - Beats spaced exactly 3 cycles apart.
- Async reset asserted mid-WRITE:
  - ram_clk_enable and ram_write_enable drop in the same cycle; grant=00.
  - After release, IDLE and req0 wins contention.
- With RAM_ARB_WATCHDOG_EN: req1 sends 2 beats without last, then drops valid for 255 cycles:
  - timeout_err pulses once; grant goes to 00, then 01 for pending req0.
  - Without the macro, grant stays 10 indefinitely.
- Alternating single-beat requests, both always valid:
  - Grants strictly alternate 01, 10, 01, ….
  - No write is lost; all 8 addresses and data match the sent values.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and defaults for the line-RAM write arbiter.
// States, one-hot grant encodings and default bus widths live here so the
// arbiter, its interface and any bench agree on them.
package ram_arb_pkg;

  localparam int DEF_ADDR_WIDTH     = 12;
  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_CE_CYCLES      = 2;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  // Strobe counter width; covers the legal CE window of 1..15 cycles.
  localparam int CE_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WRITE = 2'd2
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_REQ0 = 2'b01;
  localparam logic [1:0] GNT_REQ1 = 2'b10;

  // Requester index (0/1) to its one-hot grant.
  function automatic logic [1:0] gnt_of(input logic idx);
    return idx ? GNT_REQ1 : GNT_REQ0;
  endfunction

endpackage

// File: rtl/ram_write_arbiter_if.sv
// ram_write_arbiter_if: requester beat handshakes plus the RAM write port
// and status seen by the arbiter. slave = arbiter side, master = the
// requesters / RAM side that drives beats and observes the strobes.
interface ram_write_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
);
  logic                  req0_valid;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_last;
  logic                  req0_ready;

  logic                  req1_valid;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_last;
  logic                  req1_ready;

  logic [DATA_WIDTH-1:0] ram_data_out;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic                  ram_write_enable;
  logic                  ram_clk_enable;
  logic [1:0]            grant;
  logic                  busy;
  logic                  timeout_err;

  modport slave (
    input  req0_valid, req0_addr, req0_data, req0_last,
    input  req1_valid, req1_addr, req1_data, req1_last,
    output req0_ready, req1_ready,
    output ram_data_out, ram_address, ram_write_enable, ram_clk_enable,
    output grant, busy, timeout_err
  );

  modport master (
    output req0_valid, req0_addr, req0_data, req0_last,
    output req1_valid, req1_addr, req1_data, req1_last,
    input  req0_ready, req1_ready,
    input  ram_data_out, ram_address, ram_write_enable, ram_clk_enable,
    input  grant, busy, timeout_err
  );
endinterface

// File: rtl/ram_strobe_timer.sv
// ram_strobe_timer: down-counter that opens the RAM clock-enable window.
// load presets the count; running is high while the count is non-zero and
// done flags the final cycle of the window so the caller can leave WRITE
// on the same edge the window closes.
module ram_strobe_timer
  import ram_arb_pkg::*;
#(
  parameter int CNT_W = CE_CNT_W
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             running,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  assign running = (cnt != '0);
  assign done    = (cnt == CNT_W'(1));

  // Preset on load, otherwise count the window down to zero.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset)        cnt <= '0;
    else if (load)    cnt <= load_val;
    else if (running) cnt <= cnt - CNT_W'(1);
  end

endmodule

// File: rtl/ram_write_arbiter.sv
// ram_write_arbiter: shares the framebuffer line-RAM write port between the
// UART line loader (req0) and a secondary writer (req1). Round-robin grant,
// locked for a whole burst until a beat flagged last finishes its write.
// Each accepted beat is registered onto the RAM port and strobed for
// CE_CYCLES cycles, so one byte lands every CE_CYCLES+1 cycles.
// Optional mid-burst watchdog: define RAM_ARB_WATCHDOG_EN.
module ram_write_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int CE_CYCLES      = DEF_CE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               clk_in,
  input  logic               reset,
  ram_write_arbiter_if.slave bus
);

  if (CE_CYCLES < 1 || CE_CYCLES > 15) begin : g_bad_ce
    $error("ram_write_arbiter: CE_CYCLES must be 1..15");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_to
    $error("ram_write_arbiter: TIMEOUT_CYCLES must be 1..255");
  end

  arb_state_e            state, state_nxt;
  logic [1:0]            grant_q, grant_nxt;
  logic                  last_grant_q, last_grant_nxt;  // index of last owner
  logic [1:0]            req_valid;
  logic                  sel, owner_valid, accept;
  logic                  beat_last_q, we_q;
  logic [ADDR_WIDTH-1:0] addr_q, beat_addr;
  logic [DATA_WIDTH-1:0] data_q, beat_data;
  logic                  beat_last;
  logic                  tmr_running, tmr_done;
  logic                  wd_fire, wd_err;

  assign req_valid   = {bus.req1_valid, bus.req0_valid};
  assign sel         = grant_q[1];
  assign owner_valid = |(req_valid & grant_q);
  assign accept      = (state == GRANT) && owner_valid;

  assign beat_addr = sel ? bus.req1_addr : bus.req0_addr;
  assign beat_data = sel ? bus.req1_data : bus.req0_data;
  assign beat_last = sel ? bus.req1_last : bus.req0_last;

  // Ready depends only on registered state so it never loops back to valid.
  assign bus.req0_ready       = (state == GRANT) && grant_q[0];
  assign bus.req1_ready       = (state == GRANT) && grant_q[1];
  assign bus.ram_address      = addr_q;
  assign bus.ram_data_out     = data_q;
  assign bus.ram_write_enable = we_q;
  assign bus.ram_clk_enable   = tmr_running;
  assign bus.grant            = grant_q;
  assign bus.busy             = (state != IDLE);
  assign bus.timeout_err      = wd_err;

  ram_strobe_timer #(.CNT_W(CE_CNT_W)) u_strobe (
    .clk_in   (clk_in),
    .reset    (reset),
    .load     (accept),
    .load_val (CE_CNT_W'(CE_CYCLES)),
    .running  (tmr_running),
    .done     (tmr_done)
  );

`ifdef RAM_ARB_WATCHDOG_EN
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] wd_cnt;

  // Fires on the cycle the owner has been silent for WD_LIMIT GRANT cycles.
  assign wd_fire = (state == GRANT) && !owner_valid && (wd_cnt + 8'd1 == WD_LIMIT);

  // Count silent GRANT cycles; any beat or leaving GRANT restarts the count.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
      wd_err <= 1'b0;
    end else begin
      wd_err <= wd_fire;
      if (state != GRANT || accept || wd_fire) wd_cnt <= '0;
      else                                     wd_cnt <= wd_cnt + 8'd1;
    end
  end
`else
  // Without the watchdog a silent owner keeps the grant until its last beat.
  assign wd_fire = 1'b0;
  assign wd_err  = 1'b0;
`endif

  // State, owner and round-robin pointer registers.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      grant_q      <= GNT_NONE;
      last_grant_q <= 1'b1;  // req0 wins the first contention
    end else begin
      state        <= state_nxt;
      grant_q      <= grant_nxt;
      last_grant_q <= last_grant_nxt;
    end
  end

  // Arbitration and burst sequencing.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_q;
    last_grant_nxt = last_grant_q;
    case (state)
      IDLE: begin
        if (req_valid != 2'b00) begin
          state_nxt = GRANT;
          // Both asking: favour whoever did not own the port last.
          grant_nxt = (&req_valid) ? gnt_of(~last_grant_q) : req_valid;
        end
      end
      GRANT: begin
        if (accept) begin
          state_nxt = WRITE;
        end else if (wd_fire) begin
          state_nxt      = IDLE;
          grant_nxt      = GNT_NONE;
          last_grant_nxt = sel;
        end
      end
      WRITE: begin
        if (tmr_done) begin
          if (beat_last_q) begin
            state_nxt      = IDLE;
            grant_nxt      = GNT_NONE;
            last_grant_nxt = sel;
          end else begin
            state_nxt = GRANT;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = GNT_NONE;
      end
    endcase
  end

  // RAM port: capture the accepted beat and hold the write strobe for the
  // CE window; address/data keep their value between writes.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      data_q      <= '0;
      beat_last_q <= 1'b0;
      we_q        <= 1'b0;
    end else if (accept) begin
      addr_q      <= beat_addr;
      data_q      <= beat_data;
      beat_last_q <= beat_last;
      we_q        <= 1'b1;
    end else if (state == WRITE && tmr_done) begin
      we_q        <= 1'b0;
    end
  end

endmodule
